// File: rtl/maze_lane_merge_if.sv
// maze_lane_merge_if: bundles the seven-lane receive side and the merged output
// stream of one torus dimension. master = traffic source/sink around the merge,
// slave = the merge itself (consumes in_*, drives in_rdy and out_*).
interface maze_lane_merge_if #(
  parameter int LANES = 7,
  parameter int PKT_W = 23
);
  logic [LANES-1:0]       in_vld;
  logic [LANES-1:0]       in_rdy;
  logic [LANES*PKT_W-1:0] in_pkt;
  logic                   out_vld;
  logic                   out_rdy;
  logic [PKT_W-1:0]       out_pkt;
  logic [2:0]             out_lane;

  modport master (
    output in_vld, in_pkt, out_rdy,
    input  in_rdy, out_vld, out_pkt, out_lane
  );

  modport slave (
    input  in_vld, in_pkt, out_rdy,
    output in_rdy, out_vld, out_pkt, out_lane
  );
endinterface

// File: rtl/maze_lane_merge.sv
// maze_lane_merge: merges the seven per-offset IRS lanes of one torus dimension
// into a single registered packet stream. Lane i packet sits at
// bus.in_pkt[i*PKT_W +: PKT_W]; out_pkt/out_lane are registered, one entry deep.
// Ports: clk, rst (async, active-high), bus (maze_lane_merge_if.slave).
// Latency: input handshake at edge N -> output valid after edge N.
// Backpressure: out_vld & ~out_rdy forces every in_rdy low and holds out_pkt.
// Optional macro MAZE_MERGE_QOS_EN: QoS classes plus anti-starvation counter;
// without it the arbiter is plain round-robin and the qos bit is ignored.
module maze_lane_merge #(
  parameter int LANES = 7,
  parameter int PKT_W = 23
`ifdef MAZE_MERGE_QOS_EN
  , parameter int STARVE_MAX = 8
`endif
) (
  input logic clk,
  input logic rst,
  maze_lane_merge_if.slave bus
);

  logic [PKT_W-1:0] lane_pkt [LANES];
  logic [LANES-1:0] req;
  logic [LANES-1:0] cand;
  logic [LANES-1:0] grant;
  logic [2:0]       grant_idx;
  logic [2:0]       rr_ptr;
  logic             load;
  logic             xfer;

  logic             out_vld_q;
  logic [PKT_W-1:0] out_pkt_q;
  logic [2:0]       out_lane_q;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_pkt[i] = bus.in_pkt[i*PKT_W +: PKT_W];
    end
  end

  assign req = bus.in_vld;

`ifdef MAZE_MERGE_QOS_EN
  localparam int QOS_BIT = 20;

  logic [LANES-1:0] hi;
  logic [LANES-1:0] lo;
  logic [3:0]       starve_cnt;

  always_comb begin
    hi = '0;
    for (int i = 0; i < LANES; i++) begin
      hi[i] = req[i] & lane_pkt[i][QOS_BIT];
    end
  end

  assign lo = req & ~hi;

  // High class normally wins; once the low class has been passed over
  // STARVE_MAX times in a row it gets exactly one turn.
  always_comb begin
    cand = (hi != '0) ? hi : lo;
    if ((starve_cnt == 4'(STARVE_MAX)) && (lo != '0)) begin
      cand = lo;
    end
  end
`else
  assign cand = req;
`endif

  // Round-robin search starting at rr_ptr; the first hit wins.
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < LANES; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= LANES) begin
        idx = idx - LANES;
      end
      if (!found && cand[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = 3'(idx);
      end
    end
  end

  assign load       = ~out_vld_q | bus.out_rdy;
  assign xfer       = load & (|grant);
  // rst gate keeps upstream from handshaking into a register held in reset.
  assign bus.in_rdy = grant & {LANES{load & ~rst}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld_q  <= 1'b0;
      out_pkt_q  <= '0;
      out_lane_q <= '0;
      rr_ptr     <= '0;
    end else if (load) begin
      if (xfer) begin
        out_vld_q  <= 1'b1;
        out_pkt_q  <= lane_pkt[grant_idx];
        out_lane_q <= grant_idx;
        rr_ptr     <= (grant_idx == 3'(LANES-1)) ? 3'd0 : grant_idx + 3'd1;
      end else begin
        // Bubble: payload and lane hold their last value.
        out_vld_q <= 1'b0;
      end
    end
  end

`ifdef MAZE_MERGE_QOS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (xfer) begin
      if ((lo == '0) || ((hi & grant) == '0)) begin
        starve_cnt <= '0;
      end else if (starve_cnt != 4'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end
`endif

  assign bus.out_vld  = out_vld_q;
  assign bus.out_pkt  = out_pkt_q;
  assign bus.out_lane = out_lane_q;

endmodule

// File: doc/maze_lane_merge.md
# maze_lane_merge

- Node-side receive endpoint for one dimension (X or Y) of the MAZE torus links.
- Collects the seven per-offset input lanes (`xi_*`/`yi_*`) that arrive from the topology's IRS buffers.
- Arbitrates among them with QoS priority plus round-robin fairness and an anti-starvation counter.
- Presents one registered 23-bit packet stream to the node's local routing/ejection logic; two instances per node (X, Y).

## Interface
- `LANES`, 7: number of input lanes (offsets 1..7).
- `PKT_W`, 23: packet width {type[22:21], qos[20], src[19:14], tgt[13:8], data[7:0]}.
- `STARVE_MAX`, 8: consecutive high-QoS grants tolerated while a low-QoS lane waits; range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `in_vld`  in  LANES  per-lane valid from IRS output.
- `in_rdy`  out  LANES  per-lane ready to IRS.
- `in_pkt`  in  LANES*PKT_W  lane i at bits [i*PKT_W +: PKT_W].
- `out_vld`  out  1  output packet valid.
- `out_rdy`  in  1  downstream ready.
- `out_pkt`  out  PKT_W  granted packet, registered.
- `out_lane`  out  3  lane index of `out_pkt` (0..LANES-1).

## Operation
- Transfer on any interface occurs when vld & rdy are high at a rising clk edge.
- Output stage: one register entry; `load = ~out_vld | out_rdy` (accept new packet when empty or draining in the same cycle).
- Request set R = `in_vld`. High class H = lanes in R with pkt[20]=1; low class L = R & ~H.
- Candidate set C:
  - C = H if H≠0, else L.
  - Exception: C = L if `starve_cnt == STARVE_MAX` and L≠0.
- Grant: first lane in C searching upward from `rr_ptr`, wrapping LANES-1→0. Exactly one-hot or zero.
- `in_rdy = grant & {LANES{load}}`; forced all-zero while `rst` is high.
- On a transfer from lane g:
  - `out_pkt ← in_pkt[g]`, `out_lane ← g`, `out_vld ← 1`.
  - `rr_ptr ← (g==LANES-1) ? 0 : g+1`.
- If `load` and no grant: `out_vld ← 0` (bubble); `out_pkt`/`out_lane` hold.
- `starve_cnt`, 4 bits, updated on each transfer:
  - +1 (saturating at STARVE_MAX) when the granted lane is high-QoS and L≠0.
  - Cleared to 0 when the granted lane is low-QoS, or when L==0.
  - Holds when there is no transfer.
- Packet contents are passed through unmodified; no type filtering.

## Timing
- Reset values: `out_vld`=0, `out_pkt`=0, `out_lane`=0, `in_rdy`=0, `rr_ptr`=0, `starve_cnt`=0.
- Latency: input transfer at edge N → `out_vld`/`out_pkt` valid after edge N.
- Throughput: 1 packet/cycle sustained while `out_rdy`=1.
- `in_rdy` is combinational from `in_vld`, `in_pkt[qos]`, `out_vld`, `out_rdy`. No combinational path from `in_*` to `out_*`.
- Back-pressure: with `out_vld`=1 & `out_rdy`=0, all `in_rdy`=0 and `out_pkt` is stable.
- Simultaneous drain+fill: output register replaced in the same edge, no bubble.
- Reset asserted mid-packet: register content is discarded, `out_vld` drops asynchronously. Upstream IRS retains any un-handshaken packet.
- Lane deasserting valid without handshake is tolerated; grant is recomputed every cycle.

## Configuration
- `MAZE_MERGE_QOS_EN`
  - Defined: QoS classes and the starvation counter operate as above.
  - Undefined: C = R (qos bit ignored for arbitration), `starve_cnt` is not implemented, and behaviour is plain round-robin.

## Test plan
- Reset/idle: assert `rst`, all `in_vld`=7'h7F → `in_rdy`=0, `out_vld`=0; after release, first grant is lane 0 and `out_lane`=0 one cycle later.
- Round-robin: all lanes valid, low QoS, `out_rdy`=1 → `out_lane` sequence 0,1,…,6,0, one packet/cycle, payload intact per lane.
- QoS priority: lane 5 qos=1 and lane 1 qos=0 continuously valid, STARVE_MAX=8 → 8 grants to lane 5, then 1 to lane 1, repeating. With the macro undefined → strict alternation 1,5,1,5.
- Back-pressure: `out_rdy`=0 for 4 cycles with `out_vld`=1 → `out_pkt` stable and `in_rdy`=0. `out_rdy`=1 → drain and refill on the same edge.
- Wrap and bubble: only lane 6 valid, then only lane 0 → grants 6 then 0. A cycle with no valids and `out_rdy`=1 → `out_vld`=0 next cycle.
- Async reset mid-stream: `rst` pulsed between edges while `out_vld`=1 → `out_vld` goes 0 immediately; `rr_ptr` restarts at lane 0.
